// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared command/state encodings for the data-router register array
package router_pkg;

    typedef enum logic [1:0] {
        CMD_IB = 2'b00,
        CMD_SF = 2'b01,
        CMD_IF = 2'b10,
        CMD_NE = 2'b11
    } reg_cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_FIFO,
        S_DRAIN
    } seq_state_e;

endpackage

// File: rtl/kcnt_2d.sv
// rtl/kcnt_2d.sv - nested kx/ky kernel coordinate counter with wrap and last flags
module kcnt_2d #(
    parameter int KSIZE = 3,
    parameter int KW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [KW-1:0] o_kx,
    output logic [KW-1:0] o_ky,
    output logic          o_kx_wrap,
    output logic          o_ky_wrap,
    output logic          o_last
);

    localparam logic [KW-1:0] LP_KMAX = KW'(KSIZE - 1);

    logic [KW-1:0] r_kx;
    logic [KW-1:0] r_ky;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_kx <= '0;
            r_ky <= '0;
        end else if (i_en) begin
            if (o_kx_wrap) begin
                r_kx <= '0;
                r_ky <= o_ky_wrap ? '0 : r_ky + KW'(1);
            end else begin
                r_kx <= r_kx + KW'(1);
            end
        end
    end

    assign o_kx      = r_kx;
    assign o_ky      = r_ky;
    assign o_kx_wrap = (r_kx == LP_KMAX);
    assign o_ky_wrap = (r_ky == LP_KMAX);
    assign o_last    = o_kx_wrap && o_ky_wrap;

endmodule

// File: rtl/reg_array_seq.sv
// rtl/reg_array_seq.sv - register-array command sequencer; REG_ARRAY_SEQ_PERF_EN adds stall/starve counters
module reg_array_seq
    import router_pkg::*;
#(
    parameter int KSIZE = 3,
    parameter int ROWW  = 8,
    parameter int KW    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [ROWW-1:0] cfg_orows,
    input  logic            buf_valid,
    output logic            buf_ready,
    output logic [1:0]      reg_array_cmd,
    output logic            pe_valid,
    input  logic            pe_ready,
    output logic [KW-1:0]   pe_kx,
    output logic [KW-1:0]   pe_ky,
    output logic            pe_last,
    output logic            busy,
    output logic            done
`ifdef REG_ARRAY_SEQ_PERF_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     starve_cnt
`endif
);

    seq_state_e      r_state;
    reg_cmd_e        w_cmd;
    logic [ROWW-1:0] r_row;
    logic [ROWW-1:0] r_orows_m1;
    logic            r_pe_valid;
    logic            r_pe_last;
    logic [KW-1:0]   r_pe_kx;
    logic [KW-1:0]   r_pe_ky;

    logic            w_adv;
    logic            w_accept;
    logic            w_issue;
    logic            w_clr;
    logic            w_row_last;
    logic [KW-1:0]   w_kx;
    logic [KW-1:0]   w_ky;
    logic            w_kx_wrap;
    logic            w_ky_wrap;
    logic            w_klast;

    assign w_adv      = !r_pe_valid || pe_ready;
    assign w_accept   = r_pe_valid && pe_ready;
    assign w_clr      = (r_state == S_IDLE) && start;
    assign w_row_last = (r_row == r_orows_m1);

    // A stalled PE array freezes everything: no command may disturb the held window.
    always_comb begin
        w_cmd = CMD_NE;
        if (w_adv) begin
            case (r_state)
                S_LOAD:  if (buf_valid) w_cmd = CMD_IB;
                S_SHIFT: w_cmd = CMD_SF;
                S_FIFO:  w_cmd = CMD_IF;
                default: w_cmd = CMD_NE;
            endcase
        end
    end

    assign w_issue = (w_cmd != CMD_NE);

    kcnt_2d #(
        .KSIZE (KSIZE),
        .KW    (KW)
    ) u_kcnt (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_clr),
        .i_en      (w_issue),
        .o_kx      (w_kx),
        .o_ky      (w_ky),
        .o_kx_wrap (w_kx_wrap),
        .o_ky_wrap (w_ky_wrap),
        .o_last    (w_klast)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_orows_m1 <= '0;
            r_pe_valid <= 1'b0;
            r_pe_last  <= 1'b0;
            r_pe_kx    <= '0;
            r_pe_ky    <= '0;
        end else begin
            if (w_issue) begin
                r_pe_valid <= 1'b1;
                r_pe_kx    <= w_kx;
                r_pe_ky    <= w_ky;
                r_pe_last  <= w_klast && w_row_last;
            end else if (w_accept) begin
                r_pe_valid <= 1'b0;
                r_pe_last  <= 1'b0;
            end

            // kx wrap marks the end of a kernel row; with KSIZE=1 IB/IF wrap immediately.
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_row      <= '0;
                        r_orows_m1 <= (cfg_orows == '0) ? '0 : cfg_orows - ROWW'(1);
                    end
                end
                S_LOAD, S_SHIFT, S_FIFO: begin
                    if (w_issue) begin
                        if (!w_kx_wrap) begin
                            r_state <= S_SHIFT;
                        end else if (!w_ky_wrap) begin
                            r_state <= S_FIFO;
                        end else if (!w_row_last) begin
                            r_row   <= r_row + ROWW'(1);
                            r_state <= S_LOAD;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_accept) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign reg_array_cmd = w_cmd;
    assign buf_ready     = (w_cmd == CMD_IB);
    assign pe_valid      = r_pe_valid;
    assign pe_kx         = r_pe_kx;
    assign pe_ky         = r_pe_ky;
    assign pe_last       = r_pe_last;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DRAIN) && w_accept;

`ifdef REG_ARRAY_SEQ_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_starve_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_stall_cnt  <= '0;
            r_starve_cnt <= '0;
        end else begin
            if (r_pe_valid && !pe_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if ((r_state == S_LOAD) && !buf_valid && (r_starve_cnt != '1))
                r_starve_cnt <= r_starve_cnt + 32'd1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign starve_cnt = r_starve_cnt;
`endif

endmodule
